// File: rtl/mfe_window_fetch.sv
// Median filter engine front end: fetches the source image in raster order and emits one 3x3 window per pixel.
// Define MFE_REPLICATE_BORDER_EN to clamp border neighbours to the edge pixel instead of zero padding.
module mfe_window_fetch #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ready,
    output logic            busy,
    output logic [AW-1:0]   iaddr,
    input  logic [DW-1:0]   idata,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [9*DW-1:0] win_data,
    output logic [AW-1:0]   win_addr,
    output logic            done
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [2:0]  ItemNone = 3'd6;
`ifdef MFE_REPLICATE_BORDER_EN
    localparam bit Replicate = 1'b1;
`else
    localparam bit Replicate = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StFetch, StPresent, StFin} state_t;

    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [DW-1:0] r_wl [3];
    logic [DW-1:0] r_wm [3];
    logic [DW-1:0] r_wr [3];
    logic          r_iss_vld;
    logic [2:0]    r_iss_idx;
    logic          r_cap_vld;
    logic [2:0]    r_cap_idx;

    logic [RW-1:0] w_nrow;
    logic [CW-1:0] w_ncol;
    logic          w_last_win;
    logic          w_start;
    logic [2:0]    w_first;
    logic [2:0]    w_next;
    logic [1:0]    w_cap_ri;

    // Read items 0..2 fill the centre column (rows r-1..r+1), items 3..5 fill column c+1.
    function automatic logic item_ok(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                     input logic [2:0] idx);
        logic [1:0] ri;
        item_ok = 1'b1;
        ri      = (idx >= 3'd3) ? 2'(idx - 3'd3) : idx[1:0];
        if (idx < 3'd3 && col != '0) item_ok = 1'b0;
        if (idx >= 3'd3 && col == CW'(IMG_W - 1)) item_ok = 1'b0;
        if (!Replicate) begin
            if (ri == 2'd0 && row == '0) item_ok = 1'b0;
            if (ri == 2'd2 && row == RW'(IMG_H - 1)) item_ok = 1'b0;
        end
    endfunction

    function automatic logic [2:0] next_item(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                             input logic [2:0] from);
        next_item = ItemNone;
        for (int i = 5; i >= 0; i--) begin
            if (3'(i) >= from && item_ok(row, col, 3'(i))) next_item = 3'(i);
        end
    endfunction

    function automatic logic [AW-1:0] item_addr(input logic [RW-1:0] row,
                                                input logic [CW-1:0] col, input logic [2:0] idx);
        logic [CW-1:0] c;
        logic [1:0]    ri;
        int            r;
        c  = (idx >= 3'd3) ? col + CW'(1) : col;
        ri = (idx >= 3'd3) ? 2'(idx - 3'd3) : idx[1:0];
        r  = int'(row) + int'(ri) - 1;
        if (r < 0) r = 0;
        if (r > int'(IMG_H) - 1) r = int'(IMG_H) - 1;
        item_addr = {RW'(r), c};
    endfunction

    always_comb begin
        w_nrow = '0;
        w_ncol = '0;
        if (r_state == StPresent) begin
            if (r_col == CW'(IMG_W - 1)) begin
                w_nrow = r_row + RW'(1);
            end else begin
                w_nrow = r_row;
                w_ncol = r_col + CW'(1);
            end
        end
        w_last_win = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));
        w_start    = ((r_state == StIdle) && ready) ||
                     ((r_state == StPresent) && win_ready && !w_last_win);
        w_first    = next_item(w_nrow, w_ncol, 3'd0);
        w_next     = next_item(r_row, r_col, r_iss_idx + 3'd1);
        w_cap_ri   = 2'(r_cap_idx - 3'd3);
    end

    assign win_data = {r_wl[0], r_wm[0], r_wr[0],
                       r_wl[1], r_wm[1], r_wr[1],
                       r_wl[2], r_wm[2], r_wr[2]};
    assign win_addr = {r_row, r_col};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            done      <= 1'b0;
            iaddr     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_iss_vld <= 1'b0;
            r_iss_idx <= '0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            for (int k = 0; k < 3; k++) begin
                r_wl[k] <= '0;
                r_wm[k] <= '0;
                r_wr[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (ready) begin
                        r_state <= StFetch;
                        busy    <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                StFetch: begin
                    if (!r_iss_vld) begin
                        r_state   <= StPresent;
                        win_valid <= 1'b1;
                    end
                end
                StPresent: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        r_row     <= w_nrow;
                        r_col     <= w_ncol;
                        if (w_last_win) begin
                            r_state <= StFin;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= StFetch;
                        end
                    end
                end
                StFin: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase

            if (w_start) begin
                // Slots that will not be read stay zero; the last column keeps R in replicate mode.
                for (int k = 0; k < 3; k++) begin
                    if (w_ncol == '0) begin
                        r_wl[k] <= '0;
                        r_wm[k] <= '0;
                        r_wr[k] <= '0;
                    end else begin
                        r_wl[k] <= r_wm[k];
                        r_wm[k] <= r_wr[k];
                        r_wr[k] <= (Replicate && w_ncol == CW'(IMG_W - 1)) ? r_wr[k] : '0;
                    end
                end
                r_cap_vld <= 1'b0;
                if (w_first != ItemNone) begin
                    iaddr     <= item_addr(w_nrow, w_ncol, w_first);
                    r_iss_idx <= w_first;
                    r_iss_vld <= 1'b1;
                end else begin
                    r_iss_vld <= 1'b0;
                end
            end else if (r_state == StFetch) begin
                if (r_cap_vld) begin
                    if (r_cap_idx < 3'd3) begin
                        r_wm[r_cap_idx[1:0]] <= idata;
                        if (Replicate && r_col == '0) r_wl[r_cap_idx[1:0]] <= idata;
                    end else begin
                        r_wr[w_cap_ri] <= idata;
                    end
                end
                r_cap_vld <= r_iss_vld;
                r_cap_idx <= r_iss_idx;
                if (r_iss_vld) begin
                    if (w_next != ItemNone) begin
                        iaddr     <= item_addr(r_row, r_col, w_next);
                        r_iss_idx <= w_next;
                    end else begin
                        r_iss_vld <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mfe_window_fetch.sv
// Randomized bench for mfe_window_fetch on a reduced 16x16 image, checked against a pixel-array model.
module tb_mfe_window_fetch;
    localparam int W      = 16;
    localparam int H      = 16;
    localparam int AW     = 8;
    localparam int NPIX   = W * H;
    localparam int BUDGET = 30000;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [7:0]    idata;
    logic          win_valid;
    logic          win_ready;
    logic [71:0]   win_data;
    logic [AW-1:0] win_addr;
    logic          done;

    logic [7:0]    img [NPIX];
    logic [71:0]   first_win;
    int            n_tests = 0;
    int            n_fail  = 0;

    mfe_window_fetch #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_addr  (win_addr),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Image port: data for the address seen at an edge appears after that edge.
    always @(posedge clk) idata <= img[iaddr];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_window(input int a);
        logic [71:0] w;
        int r, c, rr, cc;
        logic [7:0] p;
        w = '0;
        r = a / W;
        c = a % W;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
`ifdef MFE_REPLICATE_BORDER_EN
                if (rr < 0) rr = 0;
                if (rr > H - 1) rr = H - 1;
                if (cc < 0) cc = 0;
                if (cc > W - 1) cc = W - 1;
                p = img[rr * W + cc];
`else
                if (rr < 0 || rr >= H || cc < 0 || cc >= W) p = 8'h00;
                else p = img[rr * W + cc];
`endif
                w = {w[63:0], p};
            end
        end
        return w;
    endfunction

    function automatic int exp_fetch(input int a);
        int r, c, cols, rows;
        r    = a / W;
        c    = a % W;
        cols = (c == 0) ? 2 : ((c == W - 1) ? 0 : 1);
`ifdef MFE_REPLICATE_BORDER_EN
        rows = 3;
`else
        rows = 3 - ((r == 0) ? 1 : 0) - ((r == H - 1) ? 1 : 0);
`endif
        return cols * rows + 1;
    endfunction

    task automatic run_frame(input bit rnd_stall, input bit noise_ready, input int abort_at);
        int            n_win = 0;
        int            fetch_cyc = 0;
        int            stall200 = 0;
        int            cyc = 0;
        bit            seen = 1'b0;
        bit            stalled = 1'b0;
        bit            finished = 1'b0;
        logic [71:0]   h_data;
        logic [AW-1:0] h_addr;
        logic [AW-1:0] h_iaddr;
        @(negedge clk);
        ready     = 1'b1;
        win_ready = 1'b1;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("stall_valid", {71'd0, win_valid}, 72'd1);
                check("stall_data", win_data, h_data);
                check("stall_addr", {64'd0, win_addr}, {64'd0, h_addr});
                check("stall_iaddr", {64'd0, iaddr}, {64'd0, h_iaddr});
            end
            if (abort_at > 0 && n_win == abort_at) begin
                reset = 1'b1;
                ready = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check("abort_busy", {71'd0, busy}, 72'd0);
                check("abort_valid", {71'd0, win_valid}, 72'd0);
                check("abort_done", {71'd0, done}, 72'd0);
                check("abort_iaddr", {64'd0, iaddr}, 72'd0);
                return;
            end
            if (done) begin
                check("win_count", 72'(n_win), 72'(NPIX));
                check("busy_at_done", {71'd0, busy}, 72'd0);
                finished = 1'b1;
            end
            if (win_valid && !seen) begin
                seen = 1'b1;
                check($sformatf("fetch_cyc[%0d]", n_win), 72'(fetch_cyc), 72'(exp_fetch(n_win)));
                check($sformatf("addr[%0d]", n_win), {64'd0, win_addr}, 72'(n_win));
                check($sformatf("data[%0d]", n_win), win_data, exp_window(n_win));
                if (n_win == 0) first_win = win_data;
            end
            if (!win_valid && busy) fetch_cyc++;
            if (rnd_stall && win_valid && n_win == 200 && stall200 < 5) begin
                win_ready = 1'b0;
                stall200++;
            end else if (rnd_stall) begin
                win_ready = ($urandom_range(0, 3) != 0);
            end else begin
                win_ready = 1'b1;
            end
            stalled = win_valid && !win_ready;
            h_data  = win_data;
            h_addr  = win_addr;
            h_iaddr = iaddr;
            if (win_valid && win_ready) begin
                n_win++;
                fetch_cyc = 0;
                seen      = 1'b0;
            end
            ready = (busy && noise_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!finished && cyc > BUDGET) begin
                check("timeout", 72'(n_win), 72'(NPIX));
                finished = 1'b1;
            end
        end
        @(negedge clk);
        check("done_pulse_len", {71'd0, done}, 72'd0);
        check("busy_after", {71'd0, busy}, 72'd0);
    endtask

    initial begin
        logic [71:0] exp_w0;
        reset     = 1'b1;
        ready     = 1'b0;
        win_ready = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = 8'h55;
        repeat (3) @(negedge clk);
        check("rst_busy", {71'd0, busy}, 72'd0);
        check("rst_valid", {71'd0, win_valid}, 72'd0);
        check("rst_done", {71'd0, done}, 72'd0);
        check("rst_iaddr", {64'd0, iaddr}, 72'd0);
        check("rst_data", win_data, 72'd0);
        check("rst_addr", {64'd0, win_addr}, 72'd0);
        reset = 1'b0;

        run_frame(1'b0, 1'b0, 0);
`ifdef MFE_REPLICATE_BORDER_EN
        exp_w0 = {9{8'h55}};
`else
        exp_w0 = 72'h00_00_00_00_55_55_00_55_55;
`endif
        check("const_win0", first_win, exp_w0);

        for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
        run_frame(1'b1, 1'b0, 0);

        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        run_frame(1'b1, 1'b0, 100);
        run_frame(1'b0, 1'b1, 0);
        check("win0_after_abort", first_win, exp_window(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mfe_window_fetch.md
Name: mfe_window_fetch

Overview:
- Upstream front end of the median filter engine (MFE).
- Reads the 128x128 8-bit source image from the external image port (iaddr/idata) in raster order.
- For every output pixel, assembles its 3x3 neighbourhood with zero padding at the image border.
- Hands each window to the median sorter over a valid/ready handshake, tagged with the destination address used for the result write.

Parameters:
- IMG_W, 128, image width in pixels
- IMG_H, 128, image height in pixels
- AW, 14, address width; log2(IMG_W*IMG_H)
- DW, 8, pixel width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- ready  in  1  frame start request from the host; sampled only in IDLE
- busy  out  1  high from frame accept until the last window is accepted
- iaddr  out  AW  image read address = row*IMG_W+col
- idata  in  DW  image read data; valid on the rising edge one cycle after iaddr is presented
- win_valid  out  1  window available
- win_ready  in  1  sorter accepts window
- win_data  out  9*DW  row-major window; [71:64]=(r-1,c-1) ... [39:32]=centre ... [7:0]=(r+1,c+1)
- win_addr  out  AW  raster address of the centre pixel
- done  out  1  one-cycle pulse after the final window handshake

Behaviour:
- Reset values: busy=0, win_valid=0, done=0, iaddr=0, win_data=0, win_addr=0; FSM in IDLE; all row/column counters cleared.
- Reset asserted mid-frame aborts the frame at the next edge:
  - all outputs return to their reset values;
  - any in-flight read data is discarded.
- FSM states: IDLE, FETCH, PRESENT, FIN.
- IDLE:
  - ready=1 moves to FETCH with row=0, col=0; busy rises the same edge.
  - ready while busy is ignored.
- FETCH:
  - The window is held as three 3-pixel columns (L, M, R).
  - At col=0: L is zeroed, and columns c and c+1 are fetched (6 reads).
  - At 0<col<IMG_W-1: shift L<-M, M<-R, then fetch column c+1 (3 reads).
  - At col=IMG_W-1: shift, and R is zeroed with no reads issued.
  - Within a column, reads go top to bottom, one address per cycle, back-to-back.
  - Data is captured one cycle after the address is issued.
  - Rows -1 and IMG_H are never read; their slot is loaded with 0 and no cycle is spent.
  - FETCH ends the cycle after the last capture; go to PRESENT.
- FETCH cycle counts (interior row):
  - col=0: 7 cycles
  - interior column: 4 cycles
  - last column: 1 cycle
  - On row 0 and row IMG_H-1, each column costs one read fewer.
- PRESENT:
  - win_valid=1; win_data and win_addr stay stable until win_ready=1.
  - On handshake: win_valid drops next cycle and col advances.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - If the handshake was for address IMG_W*IMG_H-1, go to FIN; otherwise go to FETCH.
- Backpressure:
  - No fetch for the next window starts until the current window is accepted.
  - win_ready while win_valid=0 is ignored.
- FIN:
  - done=1 and busy=0 for one cycle, then IDLE.
  - A new ready is accepted from the cycle after FIN.
- iaddr holds its last value while no read is active; the image port never requires a read-enable.
- Counter arithmetic:
  - row, col are unsigned log2(IMG_W) bits.
  - win_addr = {row, col}, which requires IMG_W to be a power of two.

Optional Feature:
- Macro: MFE_REPLICATE_BORDER_EN.
- Defined:
  - Out-of-range neighbours are clamped to the nearest edge pixel instead of zero.
  - Rows are clamped to 0..IMG_H-1 and reads are issued at the clamped address, so every column costs 3 reads.
  - At col=0, L is a copy of the fetched column 0 (6 reads).
  - At col=IMG_W-1, R is a copy of M.
- Undefined: zero padding exactly as described above.

Test Plan:
- Constant 0x55 image, win_ready tied 1:
  - 16384 windows in raster order;
  - window 0 = {0,0,0,0,55,55,0,55,55};
  - interior windows all 0x55;
  - done pulses once; busy low afterwards.
- Ramp image, pixel = addr[7:0], win_ready=1:
  - window at addr 129 = {00,01,02,80,81,82,00,01,02};
  - window at addr 16383 has its right column and bottom row all 0.
- Backpressure (win_ready low 5 cycles at window 200):
  - win_valid, win_data, win_addr held constant;
  - no iaddr change during the stall;
  - following windows unchanged versus the no-stall run.
- Reset pulsed at window 5000:
  - next cycle busy=0, win_valid=0;
  - re-issue ready -> window 0 reproduced identically.
- ready pulsed while busy=1 -> ignored: window sequence and total count 16384 unchanged.
- With MFE_REPLICATE_BORDER_EN, constant 0x55 image -> every window, including corners, is all 0x55; addr 0 costs 7 fetch cycles.
